// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory between the CPU core and the host/debug port.
// Each access is IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle ack) -> IDLE.
module mem_arbiter #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          mem_data_e,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam logic [2:0] CntInit = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e     state;
    logic [2:0] cnt;
    logic       last_owner;
    logic       we_q;
    logic       any_req;
    logic       winner;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        any_req = cpu_req | host_req;
        if (cpu_req && host_req) begin
            winner = ~last_owner;
        end else begin
            winner = host_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= 3'd0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_data_e <= 1'b0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state      <= StAccess;
                        cnt        <= CntInit;
                        last_owner <= winner;
                        we_q       <= winner ? host_we : cpu_we;
                        mem_addr   <= winner ? host_addr : cpu_addr;
                        mem_wdata  <= winner ? host_wdata : cpu_wdata;
                        mem_rd     <= winner ? ~host_we : ~cpu_we;
                        mem_wr     <= winner ? host_we : cpu_we;
                        mem_data_e <= winner ? host_we : cpu_we;
                        busy       <= 1'b1;
                    end
                end
                StAccess: begin
                    if (cnt == 3'd0) begin
                        state      <= StDone;
                        mem_rd     <= 1'b0;
                        mem_wr     <= 1'b0;
                        mem_data_e <= 1'b0;
                        cpu_ack    <= ~last_owner;
                        host_ack   <= last_owner;
                        if (!we_q) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    cpu_ack  <= 1'b0;
                    host_ack <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign owner = last_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table at MEM_LAT=1 plus multi-cycle
// sequences at MEM_LAT=2 (permanent contention) and MEM_LAT=3 (waiting and early drop).
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Instance a: MEM_LAT=1
    logic       ra;
    logic       a_cr, a_cw, a_hr, a_hw;
    logic [4:0] a_ca, a_ha, a_maddr;
    logic [7:0] a_cd, a_hd, a_rdata, a_mwdata, a_mrdata;
    logic       a_cack, a_hack, a_rd, a_wr, a_de, a_busy, a_own;
    assign a_mrdata = {3'b000, a_maddr} ^ 8'h36;

    mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(1)) u_a (
        .clk(clk), .rst(ra),
        .cpu_req(a_cr), .cpu_we(a_cw), .cpu_addr(a_ca), .cpu_wdata(a_cd), .cpu_ack(a_cack),
        .host_req(a_hr), .host_we(a_hw), .host_addr(a_ha), .host_wdata(a_hd), .host_ack(a_hack),
        .rdata(a_rdata), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rd(a_rd), .mem_wr(a_wr),
        .mem_data_e(a_de), .mem_rdata(a_mrdata), .busy(a_busy), .owner(a_own)
    );

    // Instance b: MEM_LAT=2
    logic       rb;
    logic       b_cr, b_cw, b_hr, b_hw;
    logic [4:0] b_ca, b_ha, b_maddr;
    logic [7:0] b_cd, b_hd, b_rdata, b_mwdata, b_mrdata;
    logic       b_cack, b_hack, b_rd, b_wr, b_de, b_busy, b_own;
    assign b_mrdata = {3'b000, b_maddr} ^ 8'h36;

    mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(2)) u_b (
        .clk(clk), .rst(rb),
        .cpu_req(b_cr), .cpu_we(b_cw), .cpu_addr(b_ca), .cpu_wdata(b_cd), .cpu_ack(b_cack),
        .host_req(b_hr), .host_we(b_hw), .host_addr(b_ha), .host_wdata(b_hd), .host_ack(b_hack),
        .rdata(b_rdata), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rd(b_rd), .mem_wr(b_wr),
        .mem_data_e(b_de), .mem_rdata(b_mrdata), .busy(b_busy), .owner(b_own)
    );

    // Instance c: MEM_LAT=3
    logic       rc;
    logic       c_cr, c_cw, c_hr, c_hw;
    logic [4:0] c_ca, c_ha, c_maddr;
    logic [7:0] c_cd, c_hd, c_rdata, c_mwdata, c_mrdata;
    logic       c_cack, c_hack, c_rd, c_wr, c_de, c_busy, c_own;
    assign c_mrdata = {3'b000, c_maddr} ^ 8'h36;

    mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(3)) u_c (
        .clk(clk), .rst(rc),
        .cpu_req(c_cr), .cpu_we(c_cw), .cpu_addr(c_ca), .cpu_wdata(c_cd), .cpu_ack(c_cack),
        .host_req(c_hr), .host_we(c_hw), .host_addr(c_ha), .host_wdata(c_hd), .host_ack(c_hack),
        .rdata(c_rdata), .mem_addr(c_maddr), .mem_wdata(c_mwdata), .mem_rd(c_rd), .mem_wr(c_wr),
        .mem_data_e(c_de), .mem_rdata(c_mrdata), .busy(c_busy), .owner(c_own)
    );

    // Inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic       cr, cw;
        logic [4:0] ca;
        logic [7:0] cd;
        logic       hr, hw;
        logic [4:0] ha;
        logic [7:0] hd;
        logic [2:0] strb;   // {mem_rd, mem_wr, mem_data_e}
        logic [1:0] ack;    // {cpu_ack, host_ack}
        logic [4:0] maddr;
        logic [7:0] mwdata;
        logic [7:0] rdat;
        logic       busy, own;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nack;
        int nrd;

        vecs[0]  = '{1'b1, 1'b0, 5'h0A, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00,
                     3'b100, 2'b00, 5'h0A, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'h0A, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00,
                     3'b000, 2'b10, 5'h0A, 8'h00, 8'h3C, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'h0A, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00,
                     3'b000, 2'b00, 5'h0A, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h1F, 8'hA5,
                     3'b011, 2'b00, 5'h1F, 8'hA5, 8'h3C, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h1F, 8'hA5,
                     3'b000, 2'b01, 5'h1F, 8'hA5, 8'h3C, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00,
                     3'b000, 2'b00, 5'h1F, 8'hA5, 8'h3C, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h04, 8'h00,
                     3'b100, 2'b00, 5'h03, 8'h00, 8'h3C, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 5'h04, 8'h00,
                     3'b000, 2'b10, 5'h03, 8'h00, 8'h35, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h04, 8'h00,
                     3'b000, 2'b00, 5'h03, 8'h00, 8'h35, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h04, 8'h00,
                     3'b100, 2'b00, 5'h04, 8'h00, 8'h35, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h04, 8'h00,
                     3'b000, 2'b01, 5'h04, 8'h00, 8'h32, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00,
                     3'b000, 2'b00, 5'h04, 8'h00, 8'h32, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00,
                     3'b000, 2'b00, 5'h04, 8'h00, 8'h32, 1'b0, 1'b1};

        ra = 1'b1; rb = 1'b1; rc = 1'b1;
        {a_cr, a_cw, a_hr, a_hw} = '0; a_ca = '0; a_ha = '0; a_cd = '0; a_hd = '0;
        {c_cr, c_cw, c_hr, c_hw} = '0; c_ca = '0; c_ha = '0; c_cd = '0; c_hd = '0;
        // b sees both requests from reset onwards
        b_cr = 1'b1; b_hr = 1'b1; b_cw = 1'b0; b_hw = 1'b0;
        b_ca = 5'h01; b_ha = 5'h02; b_cd = 8'h00; b_hd = 8'h00;

        repeat (2) @(negedge clk);
        chk("reset_strobes", 32'({a_rd, a_wr, a_de}), 32'd0);
        chk("reset_acks", 32'({a_cack, a_hack}), 32'd0);
        chk("reset_addr", 32'(a_maddr), 32'd0);
        chk("reset_wdata", 32'(a_mwdata), 32'd0);
        chk("reset_rdata", 32'(a_rdata), 32'd0);
        chk("reset_busy", 32'(a_busy), 32'd0);
        chk("reset_owner", 32'(a_own), 32'd1);
        chk("reset_b_busy", 32'(b_busy), 32'd0);
        ra = 1'b0;

        // ---- MEM_LAT=1 vector table ----
        for (int i = 0; i < 13; i++) begin
            a_cr = vecs[i].cr; a_cw = vecs[i].cw; a_ca = vecs[i].ca; a_cd = vecs[i].cd;
            a_hr = vecs[i].hr; a_hw = vecs[i].hw; a_ha = vecs[i].ha; a_hd = vecs[i].hd;
            step();
            chk($sformatf("v%0d_strobes", i), 32'({a_rd, a_wr, a_de}), 32'(vecs[i].strb));
            chk($sformatf("v%0d_acks", i), 32'({a_cack, a_hack}), 32'(vecs[i].ack));
            chk($sformatf("v%0d_addr", i), 32'(a_maddr), 32'(vecs[i].maddr));
            chk($sformatf("v%0d_wdata", i), 32'(a_mwdata), 32'(vecs[i].mwdata));
            chk($sformatf("v%0d_rdata", i), 32'(a_rdata), 32'(vecs[i].rdat));
            chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_owner", i), 32'(a_own), 32'(vecs[i].own));
            @(negedge clk);
        end

        // ---- reset during a host write's ACCESS cycle ----
        a_hr = 1'b1; a_hw = 1'b1; a_ha = 5'h15; a_hd = 8'h5A;
        step();
        chk("rstmid_wr_before", 32'({a_wr, a_de}), 32'b11);
        #2 ra = 1'b1;
        #1;
        chk("rstmid_wr_after", 32'({a_rd, a_wr, a_de}), 32'd0);
        chk("rstmid_busy", 32'(a_busy), 32'd0);
        chk("rstmid_addr", 32'(a_maddr), 32'd0);
        chk("rstmid_rdata", 32'(a_rdata), 32'd0);
        chk("rstmid_owner", 32'(a_own), 32'd1);
        @(negedge clk);
        a_hr = 1'b0; a_hw = 1'b0;
        @(negedge clk);
        ra = 1'b0;
        nack = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            nack += int'(a_hack) + int'(a_cack);
        end
        chk("rstmid_no_ack", 32'(nack), 32'd0);

        // ---- MEM_LAT=2, permanent contention: CPU, host, CPU, host ----
        @(negedge clk);
        rb = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int         n;
            int         ph;
            logic       eo;
            logic [4:0] ea;
            step();
            n  = k / 4;
            ph = k % 4;
            eo = (n % 2) == 1;
            ea = eo ? 5'h02 : 5'h01;
            if (ph == 0 || ph == 1) begin
                chk($sformatf("rr%0d_rd_p%0d", n, ph), 32'(b_rd), 32'd1);
                chk($sformatf("rr%0d_owner_p%0d", n, ph), 32'(b_own), 32'(eo));
                chk($sformatf("rr%0d_addr_p%0d", n, ph), 32'(b_maddr), 32'(ea));
            end else if (ph == 2) begin
                chk($sformatf("rr%0d_acks", n), 32'({b_cack, b_hack}), 32'({~eo, eo}));
                chk($sformatf("rr%0d_rdata", n), 32'(b_rdata), 32'(ea ^ 5'h16) | 32'h20);
                chk($sformatf("rr%0d_rd_done", n), 32'(b_rd), 32'd0);
            end else begin
                chk($sformatf("rr%0d_idle_busy", n), 32'(b_busy), 32'd0);
            end
        end

        // ---- MEM_LAT=3, host read arrives while CPU is mid-access ----
        @(negedge clk);
        rc = 1'b0;
        c_cr = 1'b1; c_ca = 5'h07;
        step();
        chk("wait_cpu_rd", 32'(c_rd), 32'd1);
        chk("wait_cpu_owner", 32'(c_own), 32'd0);
        @(negedge clk);
        c_hr = 1'b1; c_ha = 5'h09;
        step();
        step();
        chk("wait_cpu_addr_held", 32'(c_maddr), 32'h07);
        chk("wait_cpu_owner_held", 32'(c_own), 32'd0);
        step();
        chk("wait_cpu_acks", 32'({c_cack, c_hack}), 32'b10);
        chk("wait_cpu_rdata", 32'(c_rdata), 32'h31);
        @(negedge clk);
        c_cr = 1'b0;
        step();
        chk("wait_idle_busy", 32'(c_busy), 32'd0);
        chk("wait_idle_rd", 32'(c_rd), 32'd0);
        step();
        chk("wait_host_rd", 32'(c_rd), 32'd1);
        chk("wait_host_addr", 32'(c_maddr), 32'h09);
        chk("wait_host_owner", 32'(c_own), 32'd1);
        step();
        step();
        step();
        chk("wait_host_acks", 32'({c_cack, c_hack}), 32'b01);
        chk("wait_host_rdata", 32'(c_rdata), 32'h3F);
        @(negedge clk);
        c_hr = 1'b0;
        step();

        // ---- MEM_LAT=3, CPU drops req after the grant ----
        @(negedge clk);
        c_cr = 1'b1; c_ca = 5'h0B;
        step();
        chk("drop_rd_start", 32'(c_rd), 32'd1);
        @(negedge clk);
        c_cr = 1'b0;
        nack = 0;
        nrd = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            nack += int'(c_cack);
            nrd += int'(c_rd);
            chk($sformatf("drop_no_host_ack%0d", k), 32'(c_hack), 32'd0);
        end
        chk("drop_ack_count", 32'(nack), 32'd1);
        chk("drop_rd_cycles", 32'(nrd), 32'd2);
        chk("drop_busy_end", 32'(c_busy), 32'd0);
        chk("drop_rdata", 32'(c_rdata), 32'h3D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single instruction/data memory between the CPU core (fetch, operand read, STO write) and a host/debug port used for program loading and memory inspection. It sits between the requesters and the memory array. It serialises accesses with round-robin fairness and drives the memory strobes (`rd`, `wr`, `data_e`). Each completed access returns a one-cycle acknowledge to its owner.

## Interface
- `AW`, default 5: address width.
- `DW`, default 8: data width.
- `MEM_LAT`, default 1: number of cycles the strobes are held per access; legal range 1..7.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  CPU access request (level).
- `cpu_we`  in  1  CPU write (1) / read (0).
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse to CPU.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`: same meanings, host port.
- `rdata`  out  DW  read data of the last completed read, either owner.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `mem_data_e`  out  1  write-data bus enable.
- `mem_rdata`  in  DW  memory read data.
- `busy`  out  1  high whenever state is not IDLE.
- `owner`  out  1  current/last owner (0 = CPU, 1 = host).

## Operation
- Three-state FSM:
  - IDLE → ACCESS when any request is sampled high.
  - ACCESS holds for `MEM_LAT` cycles, using a down-counter loaded with `MEM_LAT-1`.
  - ACCESS → DONE when the counter is 0.
  - DONE → IDLE unconditionally.
- Arbitration happens only at the IDLE→ACCESS edge:
  - If one requester is high, it wins.
  - If both are high, the winner is the one NOT equal to `last_owner`.
  - `last_owner` updates to the winner at that edge.
- The winner's `we`, `addr` and `wdata` are latched at grant. Requester inputs are ignored for the rest of the access.
- In ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched values.
  - Read: `mem_rd`=1, `mem_wr`=0, `mem_data_e`=0.
  - Write: `mem_wr`=1, `mem_data_e`=1, `mem_rd`=0.
- Read data: `rdata` is loaded from `mem_rdata` at the edge ending the last ACCESS cycle of a read. It holds until the next read completes; writes do not change it.
- In DONE, the owner's ack is 1 for exactly one cycle. The non-owner's ack is 0.
- Requester protocol:
  - Keep `req` and its qualifiers stable until ack is seen.
  - Drop `req` at the clock edge that samples ack, i.e. registered drop at the edge ending DONE.
  - A requester that keeps `req` high after its ack is treated as a new request in the following IDLE cycle.
- If `req` is dropped mid-ACCESS, the access still completes and acks (a protocol violation, tolerated).
- Outputs in IDLE and DONE:
  - Strobes are 0.
  - `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset (async, takes effect immediately, including mid-ACCESS):
  - state=IDLE, counter=0.
  - `mem_rd`/`mem_wr`/`mem_data_e`=0, `cpu_ack`/`host_ack`=0.
  - `rdata`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0.
  - `last_owner`=1 (host), so the CPU wins the first tie; `owner`=1.
- An aborted access produces no ack, and `rdata` is not updated.
- Latency, with `req` sampled high at IDLE edge T:
  - strobes high in cycles T+1 .. T+`MEM_LAT`;
  - ack high in cycle T+`MEM_LAT`+1;
  - IDLE again at T+`MEM_LAT`+2.
- Minimum access period is `MEM_LAT`+2 cycles. With both requesters permanently active, grants strictly alternate.
- No combinational path from any `req` to strobes or ack; all outputs are registered or decoded from state.

## Test plan
- Reset → all outputs 0, `owner`=1. Assert `rst` during a write's ACCESS cycle → `mem_wr` drops the same cycle, no `host_ack`.
- CPU read, `cpu_addr`=5'h0A, memory returns 8'h3C, `MEM_LAT`=1 → `mem_rd` high 1 cycle. `cpu_ack` 2 cycles after grant edge. `rdata`=8'h3C in the ack cycle.
- Host write, `host_addr`=5'h1F, `host_wdata`=8'hA5 → `mem_wr`=`mem_data_e`=1 with `mem_addr`=1F, `mem_wdata`=A5. `host_ack` pulse; `rdata` unchanged.
- Both requests held high from reset, `MEM_LAT`=2 → grants CPU, host, CPU, host. Accesses start every 4 cycles; each ack belongs to the matching owner.
- `MEM_LAT`=3, host read issued while CPU is mid-access → host waits; host strobes begin the cycle after CPU's DONE+IDLE sequence.
- CPU drops `cpu_req` mid-ACCESS → access still completes and `cpu_ack` still pulses once; no second access starts.
